// File: rtl/usb3_hp_rx_check_if.sv
// Header-packet receive bundle for usb3_hp_rx_check.
// master: rx word source / header consumer; slave: the checker.
interface usb3_hp_rx_check_if #(
    parameter int SEQ_W = 3
);
    logic             hp_start;
    logic [31:0]      rx_data;
    logic             rx_valid;
    logic [95:0]      hdr_out;
    logic [SEQ_W-1:0] hdr_seq;
    logic             hdr_valid;
    logic             hdr_ready;
    logic             crc16_err;
    logic             lcw_err;
    logic             seq_err;
    logic             ovf_err;
    logic             abort;

    modport master (
        output hp_start, rx_data, rx_valid, hdr_ready,
        input  hdr_out, hdr_seq, hdr_valid,
        input  crc16_err, lcw_err, seq_err, ovf_err, abort
    );

    modport slave (
        input  hp_start, rx_data, rx_valid, hdr_ready,
        output hdr_out, hdr_seq, hdr_valid,
        output crc16_err, lcw_err, seq_err, ovf_err, abort
    );
endinterface

// File: rtl/usb3_hp_rx_check.sv
// USB3 link-layer header packet receive checker: CRC-16, LCW CRC-5,
// sequence check and a one-entry valid/ready header buffer.
// Ports: clk, rst (async, active-high), bus (usb3_hp_rx_check_if.slave):
//   hp_start/rx_data/rx_valid in; hdr_out/hdr_seq/hdr_valid out,
//   hdr_ready in; crc16_err/lcw_err/seq_err/ovf_err/abort pulses out.
// Build option: define USB3_HP_RX_SEQ_CHECK_EN to enable sequence
//   checking; when undefined seq_err is tied to 0.

// Link Control Word CRC-5: poly x^5+x^2+1, seed 5'h1F, LCW bit 0
// first, remainder inverted.
module usb3_crc_cw (
    input  logic [10:0] lcw,
    output logic [4:0]  crc5
);
    function automatic logic [4:0] crc5_calc(input logic [10:0] d);
        logic [4:0] c;
        logic       fb;
        c = 5'h1f;
        for (int i = 0; i < 11; i++) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        return ~c;
    endfunction

    assign crc5 = crc5_calc(lcw);
endmodule

module usb3_hp_rx_check #(
    parameter int SEQ_W = 3
) (
    input logic               clk,
    input logic               rst,
    usb3_hp_rx_check_if.slave bus
);
    localparam logic [15:0] CRC16_POLY = 16'h100B;
    localparam logic [15:0] CRC16_SEED = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DW0,
        S_DW1,
        S_DW2,
        S_DW3,
        S_CHK
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      crc_q, crc_d;
    logic [31:0]      dw0_q, dw0_d;
    logic [31:0]      dw1_q, dw1_d;
    logic [31:0]      dw2_q, dw2_d;
    logic [95:0]      hdr_out_q, hdr_out_d;
    logic [SEQ_W-1:0] hdr_seq_q, hdr_seq_d;
    logic             hdr_valid_q, hdr_valid_d;
    logic             crc16_err_q, crc16_err_d;
    logic             lcw_err_q, lcw_err_d;
    logic             seq_err_q, seq_err_d;
    logic             ovf_err_q, ovf_err_d;
    logic             abort_q, abort_d;
`ifdef USB3_HP_RX_SEQ_CHECK_EN
    logic [SEQ_W-1:0] seq_exp_q, seq_exp_d;
`endif

    logic [10:0]      lcw;
    logic [4:0]       crc5_calc;
    logic [15:0]      crc_upd;
    logic [SEQ_W-1:0] rx_seq;
    logic             crc_bad;
    logic             lcw_bad;
    logic             seq_bad;
    logic             hdr_good;
    logic             drain;
    logic             buf_free;
    logic             accept;

    // Reflected DWORD into the MSB-first parallel CRC-16 update.
    function automatic logic [15:0] crc16_dword(
        input logic [15:0] crc,
        input logic [31:0] dw
    );
        logic [31:0] rev;
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 32; i++) begin
            rev[i] = dw[31-i];
        end
        for (int i = 31; i >= 0; i--) begin
            fb = c[15] ^ rev[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
        return c;
    endfunction

    assign lcw     = bus.rx_data[26:16];
    assign rx_seq  = lcw[SEQ_W-1:0];
    assign crc_upd = crc16_dword(crc_q, bus.rx_data);

    usb3_crc_cw u_crc_cw (
        .lcw  (lcw),
        .crc5 (crc5_calc)
    );

    // Check terms are only consumed when DW3 is accepted.
    assign crc_bad = (crc_q != bus.rx_data[15:0]);
    assign lcw_bad = (crc5_calc != bus.rx_data[31:27]);
`ifdef USB3_HP_RX_SEQ_CHECK_EN
    assign seq_bad = (rx_seq != seq_exp_q);
`else
    assign seq_bad = 1'b0;
`endif
    assign hdr_good = !crc_bad && !lcw_bad && !seq_bad;

    assign drain    = hdr_valid_q & bus.hdr_ready;
    assign buf_free = !hdr_valid_q | drain;
    assign accept   = bus.rx_valid & !bus.hp_start;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        dw0_d       = dw0_q;
        dw1_d       = dw1_q;
        dw2_d       = dw2_q;
        hdr_out_d   = hdr_out_q;
        hdr_seq_d   = hdr_seq_q;
        hdr_valid_d = hdr_valid_q & !drain;
        crc16_err_d = 1'b0;
        lcw_err_d   = 1'b0;
        seq_err_d   = 1'b0;
        ovf_err_d   = 1'b0;
        abort_d     = 1'b0;
`ifdef USB3_HP_RX_SEQ_CHECK_EN
        seq_exp_d   = seq_exp_q;
`endif

        if (bus.hp_start) begin
            // HPSTART always restarts collection; mid-packet it aborts.
            state_d = S_DW0;
            crc_d   = CRC16_SEED;
            abort_d = (state_q == S_DW1) ||
                      (state_q == S_DW2) ||
                      (state_q == S_DW3);
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_DW0: begin
                    if (accept) begin
                        dw0_d   = bus.rx_data;
                        crc_d   = crc_upd;
                        state_d = S_DW1;
                    end
                end
                S_DW1: begin
                    if (accept) begin
                        dw1_d   = bus.rx_data;
                        crc_d   = crc_upd;
                        state_d = S_DW2;
                    end
                end
                S_DW2: begin
                    if (accept) begin
                        dw2_d   = bus.rx_data;
                        crc_d   = crc_upd;
                        state_d = S_DW3;
                    end
                end
                S_DW3: begin
                    if (accept) begin
                        state_d     = S_CHK;
                        crc16_err_d = crc_bad;
                        lcw_err_d   = lcw_bad;
                        seq_err_d   = !crc_bad && seq_bad;
                        if (hdr_good) begin
`ifdef USB3_HP_RX_SEQ_CHECK_EN
                            seq_exp_d = seq_exp_q + 1'b1;
`endif
                            if (buf_free) begin
                                hdr_out_d   = {dw2_q, dw1_q, dw0_q};
                                hdr_seq_d   = rx_seq;
                                hdr_valid_d = 1'b1;
                            end else begin
                                ovf_err_d = 1'b1;
                            end
                        end
                    end
                end
                S_CHK: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            crc_q       <= CRC16_SEED;
            dw0_q       <= '0;
            dw1_q       <= '0;
            dw2_q       <= '0;
            hdr_out_q   <= '0;
            hdr_seq_q   <= '0;
            hdr_valid_q <= 1'b0;
            crc16_err_q <= 1'b0;
            lcw_err_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
            abort_q     <= 1'b0;
`ifdef USB3_HP_RX_SEQ_CHECK_EN
            seq_exp_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            dw0_q       <= dw0_d;
            dw1_q       <= dw1_d;
            dw2_q       <= dw2_d;
            hdr_out_q   <= hdr_out_d;
            hdr_seq_q   <= hdr_seq_d;
            hdr_valid_q <= hdr_valid_d;
            crc16_err_q <= crc16_err_d;
            lcw_err_q   <= lcw_err_d;
            seq_err_q   <= seq_err_d;
            ovf_err_q   <= ovf_err_d;
            abort_q     <= abort_d;
`ifdef USB3_HP_RX_SEQ_CHECK_EN
            seq_exp_q   <= seq_exp_d;
`endif
        end
    end

    assign bus.hdr_out   = hdr_out_q;
    assign bus.hdr_seq   = hdr_seq_q;
    assign bus.hdr_valid = hdr_valid_q;
    assign bus.crc16_err = crc16_err_q;
    assign bus.lcw_err   = lcw_err_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.ovf_err   = ovf_err_q;
    assign bus.abort     = abort_q;
endmodule
